// File: rtl/cipher_round_sched.sv
// cipher_round_sched
//
// Shares one external iterative single-round cipher datapath between two
// requesters. A round-robin arbiter picks a requester in IDLE and latches
// its key and plaintext. The controller then pulses dp_load once and
// dp_step NUM_ROUNDS times, and presents the datapath state as the
// response. An all-zero key is rejected straight away without touching
// the datapath. A saturating counter records completed responses.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-requester request handshake (bit i = requester i)
//   req_key, req_data   requester i key/plaintext at [i*KW +: KW] / [i*DW +: DW]
//   dp_load             datapath loads dp_key/dp_data this cycle
//   dp_step             datapath applies round dp_round this cycle
//   dp_final            last round strobe (with dp_step)
//   dp_key, dp_data     latched key and plaintext of the current operation
//   dp_state            datapath state register (ciphertext source)
//   rsp_valid/rsp_ready response handshake; rsp_id owner, rsp_err rejection
//   rsp_data            ciphertext (zero for rejected requests)
//   busy                controller is not idle
//   cnt_done            saturating count of completed responses
module cipher_round_sched #(
  parameter int NUM_ROUNDS = 10,
  parameter int DW         = 128,
  parameter int KW         = 128,
  parameter int CW         = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2*KW-1:0] req_key,
  input  logic [2*DW-1:0] req_data,
  output logic            dp_load,
  output logic [KW-1:0]   dp_key,
  output logic [DW-1:0]   dp_data,
  output logic            dp_step,
  output logic [3:0]      dp_round,
  output logic            dp_final,
  input  logic [DW-1:0]   dp_state,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [DW-1:0]   rsp_data,
  output logic            rsp_err,
  output logic            busy,
  output logic [CW-1:0]   cnt_done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ROUND,
    DONE
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  state_t          state_q;
  state_t          state_d;
  logic            rr_ptr_q;
  logic [3:0]      round_q;
  logic [KW-1:0]   key_q;
  logic [DW-1:0]   data_q;
  logic            id_q;
  logic            err_q;
  logic [CW-1:0]   cnt_q;

  logic            gnt_any;
  logic            gnt_id;
  logic [KW-1:0]   gnt_key;
  logic [DW-1:0]   gnt_data;
  logic            gnt_key_zero;
  logic            rsp_fire;

  // Arbiter: a lone requester wins outright; on contention the requester
  // named by rr_ptr wins, and rr_ptr then points at the loser so it wins
  // the next contended grant.
  always_comb begin
    gnt_any      = |req_valid;
    gnt_id       = (req_valid == 2'b11) ? rr_ptr_q : req_valid[1];
    gnt_key      = gnt_id ? req_key[2*KW-1:KW]   : req_key[KW-1:0];
    gnt_data     = gnt_id ? req_data[2*DW-1:DW] : req_data[DW-1:0];
    gnt_key_zero = (gnt_key == '0);
  end

  // Next-state and strobe logic. Zero keys skip LOAD/ROUND entirely so the
  // datapath never sees them.
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    dp_load   = 1'b0;
    dp_step   = 1'b0;
    dp_final  = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          req_ready = gnt_id ? 2'b10 : 2'b01;
          state_d   = gnt_key_zero ? DONE : LOAD;
        end
      end
      LOAD: begin
        dp_load = 1'b1;
        state_d = ROUND;
      end
      ROUND: begin
        dp_step  = 1'b1;
        dp_final = (round_q == LAST_ROUND);
        if (round_q == LAST_ROUND) begin
          state_d = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_fire = rsp_valid & rsp_ready;

  // State, operation latches, round counter and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      round_q  <= '0;
      key_q    <= '0;
      data_q   <= '0;
      id_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && gnt_any) begin
        key_q    <= gnt_key;
        data_q   <= gnt_data;
        id_q     <= gnt_id;
        rr_ptr_q <= ~gnt_id;
        err_q    <= gnt_key_zero;
      end
      if (state_q == LOAD) begin
        round_q <= '0;
      end else if (state_q == ROUND) begin
        round_q <= round_q + 4'd1;
      end
      if (rsp_fire) begin
        err_q <= 1'b0;
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // The response only carries data from the datapath for accepted keys;
  // outside DONE the response fields are forced quiet.
  assign rsp_id   = id_q;
  assign rsp_err  = (state_q == DONE) & err_q;
  assign rsp_data = ((state_q == DONE) && !err_q) ? dp_state : '0;
  assign dp_round = round_q;
  assign dp_key   = key_q;
  assign dp_data  = data_q;
  assign busy     = (state_q != IDLE);
  assign cnt_done = cnt_q;

endmodule

// File: tb/tb_cipher_round_sched.sv
// tb_cipher_round_sched
//
// Testbench for cipher_round_sched. Provides a toy iterative datapath,
// drives randomized and directed requests, and predicts every response
// from a high-level cipher function and a round-robin model. Expected
// responses go into a scoreboard queue; a monitor pops and compares them
// whenever a response handshake occurs.
module tb_cipher_round_sched;

  localparam int NR = 10;
  localparam int DW = 128;
  localparam int KW = 128;
  localparam int CW = 4;

  typedef struct packed {
    logic          id;
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*KW-1:0] req_key;
  logic [2*DW-1:0] req_data;
  logic            dp_load;
  logic [KW-1:0]   dp_key;
  logic [DW-1:0]   dp_data;
  logic            dp_step;
  logic [3:0]      dp_round;
  logic            dp_final;
  logic [DW-1:0]   dp_state_r = '0;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic            busy;
  logic [CW-1:0]   cnt_done;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   exp_cnt = 0;
  int   steps   = 0;
  logic model_rr = 1'b0;

  always #5 clk = ~clk;

  cipher_round_sched #(
    .NUM_ROUNDS(NR),
    .DW        (DW),
    .KW        (KW),
    .CW        (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_key  (req_key),
    .req_data (req_data),
    .dp_load  (dp_load),
    .dp_key   (dp_key),
    .dp_data  (dp_data),
    .dp_step  (dp_step),
    .dp_round (dp_round),
    .dp_final (dp_final),
    .dp_state (dp_state_r),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .cnt_done (cnt_done)
  );

  // One round of the toy cipher: rotate, mix in the key, add round+1.
  function automatic logic [DW-1:0] round_fn(logic [DW-1:0] s, logic [KW-1:0] k,
                                              logic [3:0] r);
    return ({s[DW-2:0], s[DW-1]} ^ k) + DW'({1'b0, r} + 5'd1);
  endfunction

  // Full operation as the requester sees it: load key^data, then NR rounds.
  function automatic logic [DW-1:0] cipher(logic [KW-1:0] k, logic [DW-1:0] d);
    logic [DW-1:0] s;
    s = k ^ d;
    for (int r = 0; r < NR; r++) s = round_fn(s, k, 4'(r));
    return s;
  endfunction

  function automatic logic [KW-1:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // External datapath driven by the controller's strobes.
  always @(posedge clk) begin
    if (dp_load)      dp_state_r <= dp_key ^ dp_data;
    else if (dp_step) dp_state_r <= round_fn(dp_state_r, dp_key, dp_round);
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst       = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    nextCycle();
    rst      = 1'b0;
    model_rr = 1'b0;
  endtask

  // Presents a request and waits for the grant. The expected winner comes
  // from the round-robin model; the expected response goes to the
  // scoreboard. Returns one cycle after the grant cycle (posedge + 1).
  task automatic applyStimulus(input logic [1:0] mask, input logic [KW-1:0] k0,
                               input logic [KW-1:0] k1, input logic [DW-1:0] d0,
                               input logic [DW-1:0] d1, input bit hold,
                               input bit rand_ready, output int grant);
    int            waited = 0;
    bit            got    = 0;
    int            win;
    logic [KW-1:0] k;
    exp_t          e;
    req_valid = mask;
    req_key   = {k1, k0};
    req_data  = {d1, d0};
    grant     = -1;
    while (!got && waited < 200) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        got = 1;
      end else begin
        nextCycle();
        if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
        waited++;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_timeout: got no grant, expected one within 200 cycles");
      req_valid = 2'b00;
      return;
    end
    win = (mask == 2'b11) ? int'(model_rr) : int'(mask[1]);
    checkOutput("req_ready", DW'(req_ready), DW'((win == 1) ? 2'b10 : 2'b01));
    k      = (win == 1) ? k1 : k0;
    e.id   = 1'(win);
    e.err  = (k == '0);
    e.data = (k == '0) ? '0 : cipher(k, (win == 1) ? d1 : d0);
    sb.push_back(e);
    model_rr = 1'(win == 0);
    grant    = win;
    nextCycle();
    if (!hold) req_valid = 2'b00;
    if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int w = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && w < 300) begin
      @(negedge clk);
      w++;
    end
    checkOutput("drain_busy", DW'(busy), DW'(0));
    checkOutput("sb_empty", DW'(sb.size()), DW'(0));
    nextCycle();
  endtask

  // Monitor: protocol checks on the datapath strobes, scoreboard pop on
  // every response handshake, and the saturating completion count.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        exp_cnt = 0;
        steps   = 0;
      end else begin
        checkOutput("cnt_done", DW'(cnt_done), DW'(exp_cnt));
        if (dp_load || dp_step) checkOutput("strobe_excl", DW'(dp_load & dp_step), DW'(0));
        if (dp_load) steps = 0;
        if (dp_step) begin
          checkOutput("dp_round", DW'(dp_round), DW'(steps));
          checkOutput("dp_final", DW'(dp_final), DW'(steps == NR - 1));
          steps++;
        end
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rsp: got id %0d, expected no response", rsp_id);
          end else begin
            e = sb.pop_front();
            checkOutput("rsp_id", DW'(rsp_id), DW'(e.id));
            checkOutput("rsp_err", DW'(rsp_err), DW'(e.err));
            checkOutput("rsp_data", rsp_data, e.data);
          end
          if (exp_cnt < (1 << CW) - 1) exp_cnt++;
        end
      end
    end
  end

  initial begin
    int            g;
    int            exp_g[3] = '{0, 1, 0};
    logic [KW-1:0] k0, k1;
    logic [DW-1:0] d0, d1;
    bit            seen;
    int            w;

    rst       = 1'b1;
    req_valid = 2'b00;
    req_key   = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", DW'(busy), DW'(0));
    checkOutput("rst_rsp_valid", DW'(rsp_valid), DW'(0));
    checkOutput("rst_rsp_err", DW'(rsp_err), DW'(0));
    checkOutput("rst_dp_load", DW'(dp_load), DW'(0));
    checkOutput("rst_dp_step", DW'(dp_step), DW'(0));
    checkOutput("rst_cnt_done", DW'(cnt_done), DW'(0));
    checkOutput("rst_dp_key", dp_key, '0);
    checkOutput("rst_dp_data", dp_data, '0);
    nextCycle();
    rst = 1'b0;

    // Single request with exact cycle timing from the grant cycle T.
    k0 = 128'h000102030405060708090A0B0C0D0E0F;
    d0 = 128'h00112233445566778899AABBCCDDEEFF;
    applyStimulus(2'b01, k0, '0, d0, '0, 0, 0, g);
    for (int c = 1; c <= NR + 2; c++) begin
      @(negedge clk);
      checkOutput("single_load", DW'(dp_load), DW'(c == 1));
      checkOutput("single_step", DW'(dp_step), DW'(c >= 2 && c <= NR + 1));
      checkOutput("single_final", DW'(dp_final), DW'(c == NR + 1));
      checkOutput("single_rsp_valid", DW'(rsp_valid), DW'(c == NR + 2));
      if (c >= 2 && c <= NR + 1) checkOutput("single_round", DW'(dp_round), DW'(c - 2));
    end
    nextCycle();
    drain();

    // Contention from reset: grants alternate 0, 1, 0.
    doReset();
    k0 = rand_key() | 1;
    k1 = rand_key() | 1;
    d0 = rand_key();
    d1 = rand_key();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b11, k0, k1, d0, d1, i < 2, 0, g);
      checkOutput("contention_grant", DW'(g), DW'(exp_g[i]));
    end
    drain();

    // Backpressure: response held for 5 cycles with a competing request.
    rsp_ready = 1'b0;
    k0 = rand_key() | 1;
    d0 = rand_key();
    applyStimulus(2'b01, k0, '0, d0, '0, 0, 0, g);
    seen = 0;
    w    = 0;
    while (!seen && w < 40) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
      else w++;
    end
    checkOutput("bp_reach_done", DW'(seen), DW'(1));
    if (seen) begin
      for (int i = 0; i < 5; i++) begin
        if (i > 0) @(negedge clk);
        checkOutput("bp_rsp_valid", DW'(rsp_valid), DW'(1));
        checkOutput("bp_rsp_data", rsp_data, cipher(k0, d0));
        checkOutput("bp_req_ready", DW'(req_ready), DW'(0));
        checkOutput("bp_strobes", DW'(dp_load | dp_step), DW'(0));
        nextCycle();
        req_valid = 2'b10;
      end
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_final_valid", DW'(rsp_valid), DW'(1));
      nextCycle();
      @(negedge clk);
      checkOutput("bp_idle", DW'(busy), DW'(0));
    end
    rsp_ready = 1'b1;
    nextCycle();
    drain();

    // Zero key from requester 1: immediate error response.
    applyStimulus(2'b10, rand_key(), '0, rand_key(), rand_key(), 0, 0, g);
    @(negedge clk);
    checkOutput("zk_rsp_valid", DW'(rsp_valid), DW'(1));
    checkOutput("zk_rsp_err", DW'(rsp_err), DW'(1));
    checkOutput("zk_rsp_id", DW'(rsp_id), DW'(1));
    checkOutput("zk_rsp_data", rsp_data, '0);
    checkOutput("zk_dp_load", DW'(dp_load), DW'(0));
    checkOutput("zk_dp_step", DW'(dp_step), DW'(0));
    nextCycle();
    drain();

    // Reset while round 4 is being applied.
    applyStimulus(2'b01, rand_key() | 1, '0, rand_key(), '0, 0, 0, g);
    seen = 0;
    w    = 0;
    while (!seen && w < 40) begin
      @(negedge clk);
      if (dp_step && dp_round == 4'd4) seen = 1;
      else w++;
    end
    checkOutput("mr_reach_round4", DW'(seen), DW'(1));
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mr_busy", DW'(busy), DW'(0));
    checkOutput("mr_dp_step", DW'(dp_step), DW'(0));
    checkOutput("mr_rsp_valid", DW'(rsp_valid), DW'(0));
    checkOutput("mr_cnt_done", DW'(cnt_done), DW'(0));
    nextCycle();
    rst      = 1'b0;
    model_rr = 1'b0;
    applyStimulus(2'b01, rand_key() | 1, '0, rand_key(), '0, 0, 0, g);
    drain();

    // Randomized mix of masks, zero keys and response stalls.
    for (int n = 0; n < 24; n++) begin
      k0 = ($urandom_range(0, 3) == 0) ? '0 : rand_key();
      k1 = ($urandom_range(0, 3) == 0) ? '0 : rand_key();
      applyStimulus(2'($urandom_range(1, 3)), k0, k1, rand_key(), rand_key(), 0, 1, g);
    end
    rsp_ready = 1'b1;
    drain();

    // Saturation: 2^CW+2 completions after reset, counter pins at all ones.
    doReset();
    for (int n = 0; n < (1 << CW) + 2; n++) begin
      applyStimulus(2'($urandom_range(1, 3)), '0, '0, rand_key(), rand_key(), 0, 0, g);
    end
    drain();
    @(negedge clk);
    checkOutput("cnt_saturated", DW'(cnt_done), DW'(15));
    nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
